// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Game-flow controller for the shooting game core. It steps the game through
// IDLE -> READY (countdown) -> PLAY -> OVER. It issues the per-frame update
// strobe and the playfield clear request, and it keeps the score and the
// remaining lives.
//
// Ports:
//   clk_i         game clock; the same clock as the VGA timing generator
//   rst_i         synchronous reset, active-high
//   start_i       raw start button; asynchronous, active-high level
//   vsync_i       VGA vertical sync, active-low, synchronous to clk_i
//   enemy_hit_i   one-cycle pulse, an enemy was destroyed
//   player_hit_i  one-cycle pulse, the player was struck
//   state_o       phase: 0 IDLE, 1 READY, 2 PLAY, 3 OVER (also the FSM debug view)
//   run_o         high while in PLAY
//   frame_tick_o  one-cycle per-frame strobe, PLAY only
//   clear_req_o   one-cycle pulse asking the datapath to reinitialise sprites
//   score_o       current score, saturating
//   lives_o       remaining lives
//   game_over_o   high while in OVER
//
// Every output is a flop. All pulse inputs and outputs are single-cycle and
// take effect at the clock edge that samples them. There is no backpressure.
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int LIVES_INIT       = 3,
    parameter int SCORE_W          = 12,
    parameter int POINTS           = 1,
    parameter int COUNTDOWN_FRAMES = 60,
    parameter int OVER_FRAMES      = 180
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               vsync_i,
    input  logic               enemy_hit_i,
    input  logic               player_hit_i,
    output logic [1:0]         state_o,
    output logic               run_o,
    output logic               frame_tick_o,
    output logic               clear_req_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [2:0]         lives_o,
    output logic               game_over_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W:0]   POINTS_EXT = (SCORE_W+1)'(POINTS);
    localparam logic [2:0]         LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [7:0]         CD_LAST    = 8'(COUNTDOWN_FRAMES - 1);
    localparam logic [7:0]         OV_LAST    = 8'(OVER_FRAMES - 1);

    state_t             state_q;
    logic [7:0]         frame_cnt_q;
    logic               s1_q, s2_q, s3_q;
    logic               vsync_q;
    logic               run_q, frame_tick_q, clear_req_q, game_over_q;
    logic [SCORE_W-1:0] score_q;
    logic [2:0]         lives_q;

    logic               start_pulse;
    logic               frame_edge;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_inc_d;

    always_comb begin
        // s1 is the metastability stage. The edge is taken between s2 and s3.
        // Because the chain resets to 1, a button held through reset gives no edge.
        start_pulse = s2_q & ~s3_q;
        // vsync is active-low, so a new frame begins on its falling edge.
        frame_edge  = vsync_q & ~vsync_i;
        // One extra bit catches the carry, which clamps the score instead of wrapping.
        score_sum   = {1'b0, score_q} + POINTS_EXT;
        score_inc_d = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= 8'd0;
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            s3_q         <= 1'b1;
            vsync_q      <= 1'b1;
            run_q        <= 1'b0;
            frame_tick_q <= 1'b0;
            clear_req_q  <= 1'b0;
            game_over_q  <= 1'b0;
            score_q      <= '0;
            lives_q      <= 3'd0;
        end else begin
            s1_q         <= start_i;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            vsync_q      <= vsync_i;
            frame_tick_q <= 1'b0;
            clear_req_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state_q     <= ST_READY;
                        frame_cnt_q <= 8'd0;
                        score_q     <= '0;
                        lives_q     <= LIVES_LOAD;
                        clear_req_q <= 1'b1;
                    end
                end

                ST_READY: begin
                    if (frame_edge) begin
                        if (frame_cnt_q == CD_LAST) begin
                            // The edge that ends the countdown is not a play frame, so no tick.
                            state_q     <= ST_PLAY;
                            frame_cnt_q <= 8'd0;
                            run_q       <= 1'b1;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end

                ST_PLAY: begin
                    if (frame_edge) begin
                        frame_tick_q <= 1'b1;
                    end
                    if (enemy_hit_i) begin
                        score_q <= score_inc_d;
                    end
                    if (player_hit_i && lives_q != 3'd0) begin
                        lives_q <= lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            // The last life is lost, so the game ends on this same edge.
                            state_q     <= ST_OVER;
                            frame_cnt_q <= 8'd0;
                            run_q       <= 1'b0;
                            game_over_q <= 1'b1;
                        end
                    end
                end

                ST_OVER: begin
                    // A restart takes priority over a timeout on the same edge.
                    if (start_pulse) begin
                        state_q     <= ST_READY;
                        frame_cnt_q <= 8'd0;
                        score_q     <= '0;
                        lives_q     <= LIVES_LOAD;
                        clear_req_q <= 1'b1;
                        game_over_q <= 1'b0;
                    end else if (frame_edge) begin
                        if (frame_cnt_q == OV_LAST) begin
                            state_q     <= ST_IDLE;
                            frame_cnt_q <= 8'd0;
                            game_over_q <= 1'b0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state_o      = state_q;
    assign run_o        = run_q;
    assign frame_tick_o = frame_tick_q;
    assign clear_req_o  = clear_req_q;
    assign score_o      = score_q;
    assign lives_o      = lives_q;
    assign game_over_o  = game_over_q;

endmodule
